// File: rtl/mealy_bit_serializer_pkg.sv
// Shared types and helpers for the Mealy detector bit serializer.
// Optional status logic in the top is enabled with SER_STATUS_EN.
package mealy_ser_pkg;

  localparam int SYM_BITS_DEF = 3;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mealy_bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle between a word producer and the serializer.
interface mealy_bit_serializer_if #(
  parameter int DATA_W = 6
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_hold;
  logic              ser_bit;
  logic              ser_valid;
  logic              sym_start;
  logic              word_last;
  logic [7:0]        word_cnt;
  logic              ovf_flag;

  modport master (
    output in_data, in_valid, ser_hold,
    input  in_ready, ser_bit, ser_valid, sym_start, word_last, word_cnt, ovf_flag
  );

  modport slave (
    input  in_data, in_valid, ser_hold,
    output in_ready, ser_bit, ser_valid, sym_start, word_last, word_cnt, ovf_flag
  );

endinterface

// File: rtl/mealy_bit_serializer_fifo.sv
// Synchronous word FIFO feeding the serializer; extra pointer MSB separates full from empty.
module mealy_ser_fifo #(
  parameter int DATA_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mealy_bit_serializer.sv
// MSB-first word serializer for the 3-bit-symbol Mealy detector, with symbol/word markers.
// Define SER_STATUS_EN to add the word counter and sticky overflow flag.
module mealy_bit_serializer
  import mealy_ser_pkg::*;
#(
  parameter int DATA_W     = 6,
  parameter int SYM_BITS   = SYM_BITS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  mealy_bit_serializer_if.slave bus
);

  localparam int CW = cnt_width(DATA_W);

  localparam logic [0:0] ST_IDLE  = 1'(SER_IDLE);
  localparam logic [0:0] ST_SHIFT = 1'(SER_SHIFT);

  logic [0:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] fifo_rd;
  logic [CW-1:0]     bit_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              shifting;
  logic              advance;
  logic              last_bit;

  assign shifting  = (state == ST_SHIFT);
  assign advance   = shifting && !bus.ser_hold;
  assign last_bit  = (bit_cnt == CW'(DATA_W - 1));
  assign fifo_push = bus.in_valid;
  // Idle pops regardless of ser_hold; in SHIFT the next word loads on the last-bit advance.
  assign fifo_pop  = !fifo_empty && (!shifting || (advance && last_bit));

  mealy_ser_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (bus.in_data),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.in_ready  = !fifo_full;
  assign bus.ser_valid = shifting;
  assign bus.ser_bit   = shifting && shreg[DATA_W-1];
  assign bus.sym_start = shifting && ((int'(bit_cnt) % SYM_BITS) == 0);
  assign bus.word_last = shifting && last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (fifo_pop) begin
      state   <= ST_SHIFT;
      shreg   <= fifo_rd;
      bit_cnt <= '0;
    end else if (advance) begin
      if (last_bit) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end else begin
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

`ifdef SER_STATUS_EN
  logic [7:0] word_cnt_q;
  logic       ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (advance && last_bit)        word_cnt_q <= word_cnt_q + 8'd1;
      if (bus.in_valid && fifo_full)  ovf_q      <= 1'b1;
    end
  end

  assign bus.word_cnt = word_cnt_q;
  assign bus.ovf_flag = ovf_q;
`else
  assign bus.word_cnt = '0;
  assign bus.ovf_flag = 1'b0;
`endif

endmodule
